// File: rtl/ball_motion.sv
// Ball position/bounce/score sequencer; outputs register on the frame tick (vcount==SCREEN_H, hcount==0).
// Latency one clock from tick, no backpressure: x/y hold a full frame, score pulses last one clock.
module ball_motion #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 32,
    parameter int SPEED        = 4,
    parameter int PAD_L_X      = 16,
    parameter int PAD_R_X      = 608,
    parameter int PAD_W        = 16,
    parameter int PAD_H        = 96,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  paddle_l_y,
    input  logic [9:0]  paddle_r_y,
    input  logic        serve,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        in_play,
    output logic        score_l,
    output logic        score_r
);

    localparam logic [10:0] X_CENTRE   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CENTRE   = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [11:0] Y_MAX      = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] SP         = 12'(SPEED);
    localparam logic [11:0] BS         = 12'(BALL_SIZE);
    localparam logic [11:0] PH         = 12'(PAD_H);
    localparam logic [11:0] L_PLANE    = 12'(PAD_L_X + PAD_W + SPEED);
    localparam logic [11:0] L_STOP     = 12'(PAD_L_X + PAD_W);
    localparam logic [11:0] R_PLANE    = 12'(PAD_R_X);
    localparam logic [11:0] R_STOP     = 12'(PAD_R_X - BALL_SIZE);
    localparam logic [9:0]  TICK_LINE  = 10'(SCREEN_H);
    localparam logic [7:0]  PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_q;
    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic        dx_left_q;
    logic        dy_up_q;
    logic [7:0]  cnt_q;
    logic        in_play_q;
    logic        score_l_q;
    logic        score_r_q;

    logic        tick;
    logic [11:0] x12, y12, pl12, pr12;
    logic        ovl_l, ovl_r;
    logic [10:0] x_d;
    logic [9:0]  y_d;
    logic        dx_left_d, dy_up_d;
    logic        miss_left, miss_right;

    always_comb begin
        tick = (vcount == TICK_LINE) && (hcount == 11'd0);
        x12  = {1'b0, x_q};
        y12  = {2'b0, y_q};
        pl12 = {2'b0, paddle_l_y};
        pr12 = {2'b0, paddle_r_y};
        // Overlap uses the pre-move y so a paddle hit is judged where the ball is now.
        ovl_l = (y12 + BS > pl12) && (y12 < pl12 + PH);
        ovl_r = (y12 + BS > pr12) && (y12 < pr12 + PH);

        y_d     = y_q;
        dy_up_d = dy_up_q;
        if (dy_up_q) begin
            if (y12 < SP) begin
                y_d     = 10'd0;
                dy_up_d = 1'b0;
            end else begin
                y_d = 10'(y12 - SP);
            end
        end else begin
            if (y12 + SP > Y_MAX) begin
                y_d     = 10'(Y_MAX);
                dy_up_d = 1'b1;
            end else begin
                y_d = 10'(y12 + SP);
            end
        end

        x_d        = x_q;
        dx_left_d  = dx_left_q;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if (dx_left_q) begin
            if (x12 <= L_PLANE) begin
                if (ovl_l) begin
                    x_d       = 11'(L_STOP);
                    dx_left_d = 1'b0;
                end else begin
                    miss_left = 1'b1;
                end
            end else begin
                x_d = 11'(x12 - SP);
            end
        end else begin
            if (x12 + BS + SP >= R_PLANE) begin
                if (ovl_r) begin
                    x_d       = 11'(R_STOP);
                    dx_left_d = 1'b1;
                end else begin
                    miss_right = 1'b1;
                end
            end else begin
                x_d = 11'(x12 + SP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            dx_left_q <= 1'b0;
            dy_up_q   <= 1'b0;
            cnt_q     <= 8'd0;
            in_play_q <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        x_q <= X_CENTRE;
                        y_q <= Y_CENTRE;
                        if (serve) begin
                            state_q   <= PLAY;
                            in_play_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (miss_left || miss_right) begin
                            // Relaunch toward the side that just conceded.
                            x_q       <= X_CENTRE;
                            y_q       <= Y_CENTRE;
                            dx_left_q <= miss_left;
                            dy_up_q   <= 1'b0;
                            cnt_q     <= 8'd0;
                            in_play_q <= 1'b0;
                            score_l_q <= miss_right;
                            score_r_q <= miss_left;
                            state_q   <= PAUSE;
                        end else begin
                            x_q       <= x_d;
                            y_q       <= y_d;
                            dx_left_q <= dx_left_d;
                            dy_up_q   <= dy_up_d;
                        end
                    end
                    PAUSE: begin
                        if (cnt_q == PAUSE_LAST) begin
                            cnt_q   <= 8'd0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        in_play_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign in_play = in_play_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus queues hand-derived per-tick positions,
// a monitor compares them one clock after every frame tick.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  paddle_l_y;
    logic [9:0]  paddle_r_y;
    logic        serve;
    logic [10:0] x;
    logic [9:0]  y;
    logic        in_play;
    logic        score_l;
    logic        score_r;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .serve      (serve),
        .x          (x),
        .y          (y),
        .in_play    (in_play),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    typedef struct packed {
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        ip;
        logic        sl;
        logic        sr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ex, input int ey, input bit ip, input bit sl, input bit sr);
        exp_t n;
        n.ex = 11'(ex);
        n.ey = 10'(ey);
        n.ip = ip;
        n.sl = sl;
        n.sr = sr;
        q.push_back(n);
    endtask

    // y for the k-th move after a centre launch heading down.
    function automatic int y_path(input int k);
        if (k <= 56)       return 224 + 4 * k;
        else if (k == 57)  return 448;
        else if (k <= 169) return 448 - 4 * (k - 57);
        else if (k == 170) return 0;
        else               return 4 * (k - 170);
    endfunction

    task automatic frame(input bit rst_at_tick);
        @(negedge clk);
        vcount = 10'd480; hcount = 11'd0; rst_n = !rst_at_tick;
        @(negedge clk);
        vcount = 10'd480; hcount = 11'd1; rst_n = 1'b1;
        @(negedge clk);
        vcount = 10'd479; hcount = 11'd0;
        @(negedge clk);
        vcount = 10'd0;   hcount = 11'd0;
    endtask

    // Monitor: one pop per tick, then confirm the pulse drops and position holds.
    initial begin
        forever begin
            @(posedge clk);
            if (vcount == 10'd480 && hcount == 11'd0) begin
                #1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got tick, expected none (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("x", int'(x), int'(e.ex));
                    chk("y", int'(y), int'(e.ey));
                    chk("in_play", int'(in_play), int'(e.ip));
                    chk("score_l", int'(score_l), int'(e.sl));
                    chk("score_r", int'(score_r), int'(e.sr));
                    @(posedge clk);
                    #1;
                    chk("score_l_drop", int'(score_l), 0);
                    chk("score_r_drop", int'(score_r), 0);
                    chk("x_hold", int'(x), int'(e.ex));
                    chk("y_hold", int'(y), int'(e.ey));
                end
            end
        end
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got no end of stimulus, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        hcount     = 11'd0;
        vcount     = 10'd0;
        paddle_l_y = 10'd300;
        paddle_r_y = 10'd400;
        serve      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_x", int'(x), 304);
        chk("rst_y", int'(y), 224);
        chk("rst_in_play", int'(in_play), 0);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);

        // Idle frames with no serve, then launch.
        for (int i = 0; i < 2; i++) begin
            push(304, 224, 0, 0, 0);
            frame(0);
        end
        serve = 1'b1;
        push(304, 224, 1, 0, 0);
        frame(0);
        serve = 1'b0;

        // Right travel, bottom wall, right paddle hit, top wall, left miss.
        for (int k = 1; k <= 67; k++) begin
            push(304 + 4 * k, y_path(k), 1, 0, 0);
            frame(0);
        end
        push(576, y_path(68), 1, 0, 0);
        frame(0);
        for (int k = 69; k <= 203; k++) begin
            push(576 - 4 * (k - 68), y_path(k), 1, 0, 0);
            frame(0);
        end
        push(304, 224, 0, 0, 1);
        frame(0);

        // Serve held through the pause: relaunch on the 61st tick, heading left.
        serve = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            push(304, 224, 0, 0, 0);
            frame(0);
        end
        push(304, 224, 1, 0, 0);
        frame(0);
        for (int k = 1; k <= 67; k++) begin
            push(304 - 4 * k, y_path(k), 1, 0, 0);
            frame(0);
        end

        // Reset lands on the same edge as a left miss.
        paddle_l_y = 10'd0;
        push(304, 224, 0, 0, 0);
        frame(1);
        serve = 1'b0;
        push(304, 224, 0, 0, 0);
        frame(0);

        // Fresh launch to the right, then a right-side miss.
        serve = 1'b1;
        push(304, 224, 1, 0, 0);
        frame(0);
        serve = 1'b0;
        for (int k = 1; k <= 67; k++) begin
            push(304 + 4 * k, y_path(k), 1, 0, 0);
            frame(0);
        end
        paddle_r_y = 10'd0;
        push(304, 224, 0, 1, 0);
        frame(0);
        serve = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            push(304, 224, 0, 0, 0);
            frame(0);
        end
        push(304, 224, 1, 0, 0);
        frame(0);
        serve = 1'b0;

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-frame ball position generator for the pong datapath. It sits directly upstream of the ball renderer and drives that stage's `x`/`y` position inputs. It also handles wall bounces, paddle reflections, miss detection with one-cycle score pulses, and serve/pause sequencing. Position changes only at the start of vertical blanking, so the renderer never sees a mid-frame position change.

## Interface
Parameters:
- SCREEN_W, 640: active width in pixels.
- SCREEN_H, 480: active height in lines; also the frame-tick line.
- BALL_SIZE, 32: ball width and height; matches the renderer's ball size.
- SPEED, 4: pixels moved per frame on each axis.
- PAD_L_X, 16: left paddle left edge.
- PAD_R_X, 608: right paddle left edge.
- PAD_W, 16: paddle width.
- PAD_H, 96: paddle height.
- PAUSE_FRAMES, 60: frames spent in PAUSE after a score; range 1..255.

Ports:
- clk, input, 1: pixel clock shared with the renderer.
- rst_n, input, 1: synchronous, active-low reset.
- hcount, input, 11: horizontal pixel counter.
- vcount, input, 10: vertical line counter.
- paddle_l_y, input, 10: left paddle top edge.
- paddle_r_y, input, 10: right paddle top edge.
- serve, input, 1: level request to launch the ball; sampled only on a frame tick.
- x, output, 11: ball left edge; feeds the renderer `x` input.
- y, output, 10: ball top edge; feeds the renderer `y` input.
- in_play, output, 1: high while in PLAY.
- score_l, output, 1: one-cycle pulse; right player missed, point to left.
- score_r, output, 1: one-cycle pulse; left player missed, point to right.

## Operation
- Frame tick: `tick = (vcount == SCREEN_H) && (hcount == 0)`. It is combinational and high for exactly one clock per frame. All state updates below happen only on clock edges where `tick` is high.
- Reset values (rst_n low at a clock edge): x = (SCREEN_W-BALL_SIZE)/2 = 304, y = (SCREEN_H-BALL_SIZE)/2 = 224, dx = right, dy = down, state = IDLE, pause counter = 0, in_play = 0, score_l = 0, score_r = 0.
- Reset during PLAY or PAUSE takes effect at the next edge. Any pending score pulse is cleared.
- Arithmetic: all comparisons are done in 12-bit unsigned, zero-extended. Nothing wraps.
- Overlap test for paddle P: `(y + BALL_SIZE > P_y) && (y < P_y + PAD_H)`. It uses the current `y`, not the next one.
- States:
  - IDLE
    - x and y are held at centre.
    - On a tick with serve = 1: go to PLAY. No movement happens on that tick.
  - PLAY, vertical axis
    - Moving up with y < SPEED: y = 0, dy = down.
    - Moving down with y + SPEED > SCREEN_H - BALL_SIZE: y = SCREEN_H - BALL_SIZE, dy = up.
    - Otherwise: y ± SPEED.
  - PLAY, horizontal axis moving left
    - Contact plane: x − SPEED ≤ PAD_L_X + PAD_W, evaluated as x ≤ PAD_L_X + PAD_W + SPEED.
    - At the plane with left overlap: x = PAD_L_X + PAD_W, dx = right.
    - At the plane without overlap: miss; score_r pulses.
    - Otherwise: x − SPEED.
  - PLAY, horizontal axis moving right
    - Contact plane: x + BALL_SIZE + SPEED ≥ PAD_R_X.
    - At the plane with right overlap: x = PAD_R_X − BALL_SIZE, dx = left.
    - At the plane without overlap: miss; score_l pulses.
    - Otherwise: x + SPEED.
  - Both axes are evaluated on the same tick. A corner event (wall and paddle together) reflects both axes independently.
  - Miss handling
    - x and y return to centre.
    - dx is set toward the player who conceded; dy is set to down.
    - The vertical update for that tick is discarded.
    - State goes to PAUSE, pause counter = 0.
  - PAUSE
    - Each tick increments the counter.
    - On the tick where counter == PAUSE_FRAMES − 1: go to IDLE, counter = 0.
    - serve is ignored in PAUSE.
- in_play is high only in PLAY.
- score_l and score_r are never high together.

## Timing
- x, y, in_play and the score pulses are registered. They update on the edge where tick is high.
- x and y are stable from that edge until the next tick, a full frame. They are therefore constant across the entire active region.
- Latency from serve:
  - serve high at tick N gives in_play = 1 after tick N.
  - The first movement appears after tick N+1.
- Score pulse: high for the single clock after the miss tick edge. It coincides with x/y being at centre and in_play = 0.
- PAUSE duration: exactly PAUSE_FRAMES ticks. IDLE is entered after tick (miss + PAUSE_FRAMES).
- serve held continuously: the ball relaunches on the first tick in IDLE, which is PAUSE_FRAMES + 1 ticks after the miss.

## Test plan
- Reset: hold rst_n = 0 for 3 clocks, then release → x = 304, y = 224, in_play = 0, no score pulses. Outputs stay unchanged through 2 frames with serve = 0.
- Serve and move: serve = 1 at one tick → in_play = 1. On the next tick → x = 308, y = 228.
- Top wall: PLAY, moving up-right, y = 2 → tick gives y = 0 and dy = down. The following tick gives y = 4.
- Right paddle hit: paddle_r_y = 200, y = 224, x = 572, moving right → tick gives x = 576 and dx = left. The next tick gives x = 572.
- Miss and pause: paddle_r_y = 0, y = 300, x = 572, moving right → tick gives score_l pulse for exactly 1 clock, x = 304, y = 224, in_play = 0. With serve held at 1, PLAY resumes after exactly 61 ticks and the ball moves left.
- Reset mid-play: assert rst_n = 0 during PLAY on the same edge as a miss tick → no score pulse, outputs at reset values.
